mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported system memory between the CPU memory interface and one secondary bus master (DMA / display fetch).
- The CPU has no stall input, so it always has absolute priority. The secondary master gets only the cycles in which the CPU issues no access.
- Tracks the owner of every outstanding read so returned data is steered to the correct requester with a valid strobe.
- Keeps wait-time statistics for the secondary master.

Parameters:
- RD_LATENCY, 1, cycles from mem_rd asserted to valid mem_rddata (1..4).
- WAIT_W, 8, width of the wait counters.
- STARVE_LIMIT, 64, value of wait_cnt at and above which dev_starved asserts.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_mem_rd  in  1  CPU read strobe
- cpu_mem_wr  in  1  CPU write strobe
- cpu_mem_addr  in  16  CPU byte address
- cpu_mem_wrdata  in  16  CPU write data
- cpu_mem_rddata  out  16  read data to CPU
- dev_req  in  1  secondary master request, held until granted
- dev_we  in  1  1 = write, 0 = read; valid with dev_req
- dev_addr  in  16  secondary master address
- dev_wrdata  in  16  secondary master write data
- dev_gnt  out  1  access accepted this cycle
- dev_rddata  out  16  read data to secondary master
- dev_rvalid  out  1  dev_rddata valid this cycle
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  16  memory address
- mem_wrdata  out  16  memory write data
- mem_rddata  in  16  memory read data
- wait_cnt  out  WAIT_W  current consecutive ungranted cycles of dev_req
- max_wait  out  WAIT_W  largest wait_cnt reached since reset
- dev_starved  out  1  wait_cnt >= STARVE_LIMIT

Behaviour:
- **Ownership (combinational, same cycle):**
  - cpu_act = cpu_mem_rd | cpu_mem_wr.
  - If cpu_act, the CPU owns the port: mem_rd = cpu_mem_rd, mem_wr = cpu_mem_wr, mem_addr = cpu_mem_addr, mem_wrdata = cpu_mem_wrdata, dev_gnt = 0.
  - Else if dev_req: dev_gnt = 1, mem_rd = ~dev_we, mem_wr = dev_we, mem_addr = dev_addr, mem_wrdata = dev_wrdata.
  - Else: mem_rd = mem_wr = 0, and mem_addr / mem_wrdata = CPU values.
  - During reset: dev_gnt = 0 and CPU passthrough only.
- **CPU simultaneous rd and wr:** passed through unchanged; the owner tag for that cycle is CPU; no error detection.
- **Read data:**
  - cpu_mem_rddata = mem_rddata, combinational and unconditional. The CPU bus default path depends on this.
  - dev_rddata = mem_rddata, combinational.
- **Owner pipeline:**
  - A shift register RD_LATENCY deep carries one bit per cycle: 1 when a granted device read was issued (dev_gnt & ~dev_we), else 0.
  - dev_rvalid = output stage of the pipeline, so it is high exactly RD_LATENCY cycles after the granting cycle.
  - Device writes and CPU accesses never produce dev_rvalid.
  - Back-to-back granted device reads produce back-to-back dev_rvalid, one per read, in order.
- **Handshake:**
  - The device holds dev_req, dev_we, dev_addr and dev_wrdata stable until the cycle dev_gnt = 1. The transfer completes in that cycle.
  - dev_req held high after a grant is a new request.
- **Wait counter (registered):**
  - On each cycle with dev_req & ~dev_gnt, wait_cnt increments, saturating at 2^WAIT_W-1.
  - On dev_gnt or ~dev_req, wait_cnt = 0 next cycle.
  - max_wait updates to wait_cnt+1 (saturated) whenever that exceeds it; it is cleared only by reset.
  - dev_starved is combinational from wait_cnt.
- **Reset values:**
  - Owner pipeline = 0, dev_rvalid = 0, wait_cnt = 0, max_wait = 0, dev_starved = 0.
  - Reset mid-read flushes the pipeline; a read in flight never asserts dev_rvalid.
- **Boundaries:**
  - CPU access in the same cycle as a device request: CPU wins and wait_cnt increments.
  - Device request arriving in the cycle the CPU goes idle: granted that cycle (zero-latency grant).

Test Plan:
- **Idle CPU device read:** RD_LATENCY=1, CPU idle; dev_req=1, dev_we=0, dev_addr=0x0040; memory returns 0xBEEF.
  - Same cycle: dev_gnt=1, mem_rd=1, mem_addr=0x0040.
  - Next cycle: dev_rvalid=1, dev_rddata=0xBEEF.
- **Collision:** cpu_mem_rd=1 at addr 0x0002 while dev_req=1 for 3 cycles, then CPU idle.
  - CPU-owned cycles: dev_gnt=0, mem_addr=0x0002, wait_cnt 0→1→2→3.
  - Cycle 4: dev_gnt=1. Next cycle: wait_cnt=0, max_wait=3.
- **CPU store:** cpu_mem_wr=1, addr 0x0010, data 0x1234, dev_req=1 with dev_we=1.
  - mem_wr=1, mem_wrdata=0x1234, dev_gnt=0, no dev_rvalid.
  - Next idle cycle: device write granted with its own data.
- **Latency pipeline:** RD_LATENCY=3; device reads granted at cycles 0, 1, and 3.
  - dev_rvalid high exactly at cycles 3, 4 and 6.
  - A CPU read at cycle 2 produces no dev_rvalid at cycle 5.
- **Starvation:** STARVE_LIMIT=64, WAIT_W=8; CPU active continuously for 300 cycles with dev_req=1.
  - dev_starved rises when wait_cnt reaches 64.
  - wait_cnt saturates at 255; max_wait=255.
- **Reset in flight:** RD_LATENCY=2; device read granted, then reset asserted the following cycle.
  - dev_rvalid never asserts; wait_cnt=0, max_wait=0 after reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares single-ported memory between CPU and one device
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int          RD_LATENCY   = 1,
  parameter int          WAIT_W       = 8,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mem_rd,
  input  logic              cpu_mem_wr,
  input  logic [15:0]       cpu_mem_addr,
  input  logic [15:0]       cpu_mem_wrdata,
  output logic [15:0]       cpu_mem_rddata,
  input  logic              dev_req,
  input  logic              dev_we,
  input  logic [15:0]       dev_addr,
  input  logic [15:0]       dev_wrdata,
  output logic              dev_gnt,
  output logic [15:0]       dev_rddata,
  output logic              dev_rvalid,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [15:0]       mem_addr,
  output logic [15:0]       mem_wrdata,
  input  logic [15:0]       mem_rddata,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic [WAIT_W-1:0] max_wait,
  output logic              dev_starved
);

  logic                  w_cpu_act;
  logic                  w_dev_sel;
  logic                  w_dev_rd_issue;
  logic [WAIT_W-1:0]     w_wait_inc;
  logic [RD_LATENCY-1:0] r_owner_pipe;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [WAIT_W-1:0]     r_max_wait;

  // The CPU cannot be stalled, so the device only ever sees idle CPU cycles.
  assign w_cpu_act      = cpu_mem_rd | cpu_mem_wr;
  assign w_dev_sel      = ~reset & ~w_cpu_act & dev_req;
  assign w_dev_rd_issue = w_dev_sel & ~dev_we;

  always_comb begin
    mem_rd     = cpu_mem_rd;
    mem_wr     = cpu_mem_wr;
    mem_addr   = cpu_mem_addr;
    mem_wrdata = cpu_mem_wrdata;
    if (w_dev_sel) begin
      mem_rd     = ~dev_we;
      mem_wr     = dev_we;
      mem_addr   = dev_addr;
      mem_wrdata = dev_wrdata;
    end
  end

  assign dev_gnt        = w_dev_sel;
  assign cpu_mem_rddata = mem_rddata;
  assign dev_rddata     = mem_rddata;

  // One bit per cycle marks a device read; the last stage lines up with its data.
  generate
    if (RD_LATENCY == 1) begin : g_pipe_one
      always_ff @(posedge clk) begin
        if (reset) begin
          r_owner_pipe <= '0;
        end else begin
          r_owner_pipe <= w_dev_rd_issue;
        end
      end
    end else begin : g_pipe_multi
      always_ff @(posedge clk) begin
        if (reset) begin
          r_owner_pipe <= '0;
        end else begin
          r_owner_pipe <= {r_owner_pipe[RD_LATENCY-2:0], w_dev_rd_issue};
        end
      end
    end
  endgenerate

  assign dev_rvalid = r_owner_pipe[RD_LATENCY-1];

  assign w_wait_inc = (&r_wait_cnt) ? r_wait_cnt : r_wait_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_max_wait <= '0;
    end else if (dev_req & ~w_dev_sel) begin
      r_wait_cnt <= w_wait_inc;
      if (w_wait_inc > r_max_wait) begin
        r_max_wait <= w_wait_inc;
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign wait_cnt    = r_wait_cnt;
  assign max_wait    = r_max_wait;
  assign dev_starved = 32'(r_wait_cnt) >= STARVE_LIMIT;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed bench, three latency variants on shared stimulus
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mem_rd, cpu_mem_wr;
  logic [15:0] cpu_mem_addr, cpu_mem_wrdata;
  logic        dev_req, dev_we;
  logic [15:0] dev_addr, dev_wrdata;
  logic [15:0] mem_rddata;

  logic [15:0] cpu_rd1, dev_rd1, maddr1, mwd1;
  logic        gnt1, rv1, mrd1, mwr1, starved1;
  logic [7:0]  wait1, max1;

  logic [15:0] cpu_rd2, dev_rd2, maddr2, mwd2;
  logic        gnt2, rv2, mrd2, mwr2, starved2;
  logic [7:0]  wait2, max2;

  logic [15:0] cpu_rd3, dev_rd3, maddr3, mwd3;
  logic        gnt3, rv3, mrd3, mwr3, starved3;
  logic [7:0]  wait3, max3;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RD_LATENCY(1), .WAIT_W(8), .STARVE_LIMIT(64)) u_l1 (
    .clk(clk), .reset(reset), .cpu_mem_rd(cpu_mem_rd), .cpu_mem_wr(cpu_mem_wr),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wrdata(cpu_mem_wrdata), .cpu_mem_rddata(cpu_rd1),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wrdata(dev_wrdata),
    .dev_gnt(gnt1), .dev_rddata(dev_rd1), .dev_rvalid(rv1), .mem_rd(mrd1), .mem_wr(mwr1),
    .mem_addr(maddr1), .mem_wrdata(mwd1), .mem_rddata(mem_rddata),
    .wait_cnt(wait1), .max_wait(max1), .dev_starved(starved1));

  mem_port_arbiter #(.RD_LATENCY(2), .WAIT_W(8), .STARVE_LIMIT(64)) u_l2 (
    .clk(clk), .reset(reset), .cpu_mem_rd(cpu_mem_rd), .cpu_mem_wr(cpu_mem_wr),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wrdata(cpu_mem_wrdata), .cpu_mem_rddata(cpu_rd2),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wrdata(dev_wrdata),
    .dev_gnt(gnt2), .dev_rddata(dev_rd2), .dev_rvalid(rv2), .mem_rd(mrd2), .mem_wr(mwr2),
    .mem_addr(maddr2), .mem_wrdata(mwd2), .mem_rddata(mem_rddata),
    .wait_cnt(wait2), .max_wait(max2), .dev_starved(starved2));

  mem_port_arbiter #(.RD_LATENCY(3), .WAIT_W(8), .STARVE_LIMIT(64)) u_l3 (
    .clk(clk), .reset(reset), .cpu_mem_rd(cpu_mem_rd), .cpu_mem_wr(cpu_mem_wr),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wrdata(cpu_mem_wrdata), .cpu_mem_rddata(cpu_rd3),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wrdata(dev_wrdata),
    .dev_gnt(gnt3), .dev_rddata(dev_rd3), .dev_rvalid(rv3), .mem_rd(mrd3), .mem_wr(mwr3),
    .mem_addr(maddr3), .mem_wrdata(mwd3), .mem_rddata(mem_rddata),
    .wait_cnt(wait3), .max_wait(max3), .dev_starved(starved3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change 1 ns after the edge, checks at +1 ns more.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_mem_rd = 0; cpu_mem_wr = 0; dev_req = 0; dev_we = 0;
  endtask

  initial begin
    logic [8:0] exp_rv3;
    logic [8:0] exp_rv1;
    exp_rv3 = 9'b001011000;
    exp_rv1 = 9'b000010110;

    reset = 1; idle();
    cpu_mem_addr = 16'h0000; cpu_mem_wrdata = 16'h0000;
    dev_addr = 16'h0000; dev_wrdata = 16'h0000; mem_rddata = 16'h0000;
    tick(); tick();

    // Reset: no grant even with a request pending
    dev_req = 1; dev_we = 0; dev_addr = 16'h0040;
    #1;
    check("rst_gnt", gnt1, 0);
    check("rst_mem_rd", mrd1, 0);
    check("rst_wait", wait1, 0);
    check("rst_max", max1, 0);
    check("rst_rvalid", rv1, 0);
    check("rst_starved", starved1, 0);
    idle();
    reset = 0;
    tick();

    // Idle-CPU device read
    dev_req = 1; dev_we = 0; dev_addr = 16'h0040; mem_rddata = 16'hBEEF;
    #1;
    check("rd_gnt", gnt1, 1);
    check("rd_mem_rd", mrd1, 1);
    check("rd_mem_wr", mwr1, 0);
    check("rd_mem_addr", maddr1, 16'h0040);
    tick();
    idle();
    #1;
    check("rd_rvalid_l1", rv1, 1);
    check("rd_rddata", dev_rd1, 16'hBEEF);
    check("rd_cpu_rddata", cpu_rd1, 16'hBEEF);
    check("rd_rvalid_l2_early", rv2, 0);
    tick();
    check("rd_rvalid_l1_off", rv1, 0);
    check("rd_rvalid_l2", rv2, 1);
    tick();
    check("rd_rvalid_l3", rv3, 1);
    tick();

    // Collision: CPU reads for 3 cycles while device waits
    cpu_mem_rd = 1; cpu_mem_addr = 16'h0002;
    dev_req = 1; dev_we = 0; dev_addr = 16'h0080;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("col_gnt", gnt1, 0);
      check("col_addr", maddr1, 16'h0002);
      check("col_wait", wait1, i);
      check("col_rvalid", rv1, 0);
      tick();
    end
    cpu_mem_rd = 0;
    #1;
    check("col_gnt_idle", gnt1, 1);
    check("col_wait3", wait1, 3);
    check("col_addr_dev", maddr1, 16'h0080);
    tick();
    idle();
    #1;
    check("col_wait_clr", wait1, 0);
    check("col_max", max1, 3);
    check("col_rvalid_dev", rv1, 1);
    tick();

    // CPU store wins over device write
    cpu_mem_wr = 1; cpu_mem_addr = 16'h0010; cpu_mem_wrdata = 16'h1234;
    dev_req = 1; dev_we = 1; dev_addr = 16'h0020; dev_wrdata = 16'h5678;
    #1;
    check("st_mem_wr", mwr1, 1);
    check("st_mem_rd", mrd1, 0);
    check("st_wrdata", mwd1, 16'h1234);
    check("st_gnt", gnt1, 0);
    tick();
    cpu_mem_wr = 0;
    #1;
    check("st_dev_gnt", gnt1, 1);
    check("st_dev_wr", mwr1, 1);
    check("st_dev_rd", mrd1, 0);
    check("st_dev_wrdata", mwd1, 16'h5678);
    check("st_dev_addr", maddr1, 16'h0020);
    check("st_rvalid_cpu", rv1, 0);
    tick();
    idle();
    #1;
    check("st_rvalid_devwr", rv1, 0);
    check("st_max_keep", max1, 3);
    tick(); tick(); tick(); tick();

    // Latency pipeline: device reads at 0,1,3, CPU read at 2
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c == 0 || c == 1 || c == 3) begin
        dev_req = 1; dev_we = 0; dev_addr = 16'(16'h0100 + c);
      end
      if (c == 2) begin
        cpu_mem_rd = 1; cpu_mem_addr = 16'h0004;
      end
      #1;
      check($sformatf("lat_rv3_c%0d", c), rv3, exp_rv3[c]);
      check($sformatf("lat_rv1_c%0d", c), rv1, exp_rv1[c]);
      tick();
    end
    idle();

    // Starvation: CPU busy 300 cycles with a pending device request
    cpu_mem_rd = 1; cpu_mem_addr = 16'h0006;
    dev_req = 1; dev_we = 0; dev_addr = 16'h0200;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (k == 63) begin
        check("stv_wait63", wait1, 63);
        check("stv_not_starved", starved1, 0);
      end
      if (k == 64) begin
        check("stv_wait64", wait1, 64);
        check("stv_starved", starved1, 1);
      end
      if (k == 299) begin
        check("stv_wait_sat", wait1, 255);
        check("stv_max_sat", max1, 255);
        check("stv_gnt", gnt1, 0);
      end
      tick();
    end
    cpu_mem_rd = 0;
    #1;
    check("stv_grant", gnt1, 1);
    tick();
    idle();
    #1;
    check("stv_wait_clr", wait1, 0);
    check("stv_max_hold", max1, 255);
    check("stv_starved_clr", starved1, 0);
    tick(); tick(); tick();

    // Reset with a device read in flight
    dev_req = 1; dev_we = 0; dev_addr = 16'h0300;
    #1;
    check("rif_gnt", gnt2, 1);
    tick();
    idle();
    reset = 1;
    #1;
    check("rif_rv2_c1", rv2, 0);
    tick();
    reset = 0;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("rif_rv2", rv2, 0);
      check("rif_rv3", rv3, 0);
      tick();
    end
    check("rif_wait", wait2, 0);
    check("rif_max", max2, 0);
    check("rif_max_l1", max1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
